depp_reg_bridge: RTL

//  Downstream companion of the DEPP port logic. Synchronises the async DEPP pins,

---
 rtl/depp_reg_bridge.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/depp_reg_bridge.sv
// DEPP pin-side bridge: synchronises the async host strobes and data, decodes address/data
// read/write cycles, and drives a single-cycle register bus with a wait-handshake back to the host.
module depp_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 255,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_astb,
  input  logic       a_dstb,
  input  logic       a_write,
  input  logic [7:0] a_db_i,
  output logic [7:0] a_db_o,
  output logic       a_db_oe,
  output logic       a_wait,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvalid,
  output logic       rd_timeout
);

  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] astb_sync_q, dstb_sync_q, write_sync_q;
  logic [7:0]             db_sync_q [SYNC_STAGES];
  logic                   astb_hist_q, dstb_hist_q;

  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [7:0]       db_o_q, db_o_d;
  logic             oe_q, oe_d;
  logic             wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_cyc_q, data_cyc_d;

  logic       astb_s, dstb_s, write_s;
  logic [7:0] db_s;
  logic       astb_fall_s, dstb_fall_s;

  assign astb_s  = astb_sync_q[SYNC_STAGES-1];
  assign dstb_s  = dstb_sync_q[SYNC_STAGES-1];
  assign write_s = write_sync_q[SYNC_STAGES-1];
  assign db_s    = db_sync_q[SYNC_STAGES-1];

  // History resets to 0, so a strobe already low when reset lifts never reads as a fall.
  assign astb_fall_s = astb_hist_q & ~astb_s;
  assign dstb_fall_s = dstb_hist_q & ~dstb_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      astb_sync_q  <= '0;
      dstb_sync_q  <= '0;
      write_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) db_sync_q[i] <= 8'h00;
      astb_hist_q  <= 1'b0;
      dstb_hist_q  <= 1'b0;
    end else begin
      astb_sync_q  <= {astb_sync_q[SYNC_STAGES-2:0], a_astb};
      dstb_sync_q  <= {dstb_sync_q[SYNC_STAGES-2:0], a_dstb};
      write_sync_q <= {write_sync_q[SYNC_STAGES-2:0], a_write};
      db_sync_q[0] <= a_db_i;
      for (int i = 1; i < SYNC_STAGES; i++) db_sync_q[i] <= db_sync_q[i-1];
      astb_hist_q  <= astb_s;
      dstb_hist_q  <= dstb_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      db_o_q     <= 8'h00;
      oe_q       <= 1'b0;
      wait_q     <= 1'b0;
      tmo_q      <= 1'b0;
      cnt_q      <= '0;
      data_cyc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      db_o_q     <= db_o_d;
      oe_q       <= oe_d;
      wait_q     <= wait_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      data_cyc_q <= data_cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    db_o_d     = db_o_q;
    oe_d       = oe_q;
    wait_d     = 1'b0;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    data_cyc_d = data_cyc_q;
    case (state_q)
      IDLE: begin
        // Address strobe wins when both fall together; the data strobe is then dropped.
        if (astb_fall_s) begin
          data_cyc_d = 1'b0;
          if (!write_s) begin
            addr_d = db_s;
          end else begin
            db_o_d = addr_q;
            oe_d   = 1'b1;
          end
          state_d = ACK;
          wait_d  = 1'b1;
        end else if (dstb_fall_s) begin
          data_cyc_d = 1'b1;
          if (!write_s) begin
            wdata_d = db_s;
            we_d    = 1'b1;
            state_d = ACK;
            wait_d  = 1'b1;
          end else begin
            re_d    = 1'b1;
            cnt_d   = '0;
            state_d = RD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (reg_rvalid) begin
          db_o_d  = reg_rdata;
          oe_d    = 1'b1;
          state_d = ACK;
          wait_d  = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          db_o_d  = 8'hFF;
          oe_d    = 1'b1;
          tmo_d   = 1'b1;
          state_d = ACK;
          wait_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ACK: begin
        if (astb_s && dstb_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          wait_d  = 1'b0;
          if (AUTO_INC && data_cyc_q) begin
            addr_d = addr_q + 8'd1;
          end else begin
            addr_d = addr_q;
          end
        end else begin
          wait_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  assign a_db_o     = db_o_q;
  assign a_db_oe    = oe_q;
  assign a_wait     = wait_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign rd_timeout = tmo_q;

endmodule
